// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: captures fetched instructions, resolves
// B-type / JAL / JALR once operands are ready, and keeps saturating
// control-flow statistics for the fetch-stage predictor.
module branch_resolve_unit #(
    parameter int PC_SIZE   = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    input  logic [PC_SIZE-1:0]   pc,
    input  logic                 flush,
    input  logic                 hold,
    input  logic [31:0]          rs1_val,
    input  logic [31:0]          rs2_val,
    input  logic                 opnd_rdy,
    output logic                 b_eval,
    output logic                 branch_outcome,
    output logic                 trgt_gen,
    output logic [PC_SIZE-1:0]   alupc,
    output logic                 jr_bpu,
    output logic [PC_SIZE-1:0]   jr_in,
    output logic                 stall_req,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] jmp_cnt
);

    localparam logic [6:0] BTYPE_OP = 7'b1100011;
    localparam logic [6:0] JAL_OP   = 7'b1101111;
    localparam logic [6:0] JALR_OP  = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {C_NONE, C_BR, C_JAL, C_JALR} cls_t;

    state_t state, next_state;
    cls_t   cls;

    logic               dec_valid;
    logic [31:0]        dec_instr;
    logic [PC_SIZE-1:0] dec_pc;

    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [11:0] i_imm;
    logic               resolve;
    logic               br_taken;

    // Decode register: captures fetch unless downstream holds or we are stalling on operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_instr <= '0;
            dec_pc    <= '0;
        end else if (!hold && !stall_req) begin
            dec_valid <= instr_valid & ~flush;
            dec_instr <= instr;
            dec_pc    <= pc;
        end
    end

    // Classify the instruction sitting in decode
    always_comb begin
        cls = C_NONE;
        if (dec_valid) begin
            case (dec_instr[6:0])
                BTYPE_OP: cls = C_BR;
                JAL_OP:   cls = C_JAL;
                JALR_OP:  cls = C_JALR;
                default:  cls = C_NONE;
            endcase
        end
    end

    assign b_imm = {dec_instr[31], dec_instr[7], dec_instr[30:25], dec_instr[11:8], 1'b0};
    assign j_imm = {dec_instr[31], dec_instr[19:12], dec_instr[20], dec_instr[30:21], 1'b0};
    assign i_imm = dec_instr[31:20];

    // Target adders; forced to zero when no matching instruction is in decode
    always_comb begin
        alupc = '0;
        jr_in = '0;
        if (cls == C_BR)
            alupc = dec_pc + PC_SIZE'(b_imm);
        else if (cls == C_JAL)
            alupc = dec_pc + PC_SIZE'(j_imm);
        if (cls == C_JALR)
            jr_in = (PC_SIZE'(rs1_val) + PC_SIZE'(i_imm)) & ~PC_SIZE'(1);
    end

    // Branch comparison selected by funct3; reserved encodings never take
    always_comb begin
        br_taken = 1'b0;
        case (dec_instr[14:12])
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // State register for the resolution FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Resolution strobes, stall request and next state; DONE blocks re-pulsing while held
    always_comb begin
        next_state     = state;
        b_eval         = 1'b0;
        branch_outcome = 1'b0;
        trgt_gen       = 1'b0;
        jr_bpu         = 1'b0;
        stall_req      = 1'b0;
        resolve        = (cls != C_NONE) && (state != S_DONE) && ((cls == C_JAL) || opnd_rdy);

        if (resolve) begin
            case (cls)
                C_BR: begin
                    b_eval         = 1'b1;
                    branch_outcome = br_taken;
                end
                C_JAL:   trgt_gen = 1'b1;
                C_JALR:  jr_bpu   = 1'b1;
                default: ;
            endcase
        end

        stall_req = ((cls == C_BR) || (cls == C_JALR)) && (state != S_DONE) && !opnd_rdy;

        case (state)
            S_DONE: begin
                if (!hold)
                    next_state = S_IDLE;
            end
            default: begin
                if (resolve)
                    next_state = hold ? S_DONE : S_IDLE;
                else if (stall_req)
                    next_state = S_WAIT;
                else
                    next_state = S_IDLE;
            end
        endcase
    end

    // Saturating statistics counters, updated on the edge ending a strobe cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            jmp_cnt   <= '0;
        end else begin
            if (b_eval && (br_cnt != '1))
                br_cnt <= br_cnt + CNT_WIDTH'(1);
            if (b_eval && branch_outcome && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_WIDTH'(1);
            if ((trgt_gen || jr_bpu) && (jmp_cnt != '1))
                jmp_cnt <= jmp_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; a second instance
// with 4-bit counters shares the stimulus to exercise counter saturation.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        hold;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        opnd_rdy;

    logic        b_eval, branch_outcome, trgt_gen, jr_bpu, stall_req;
    logic [31:0] alupc, jr_in, br_cnt, taken_cnt, jmp_cnt;

    logic        s_b_eval, s_branch_outcome, s_trgt_gen, s_jr_bpu, s_stall_req;
    logic [31:0] s_alupc, s_jr_in;
    logic [3:0]  s_br_cnt, s_taken_cnt, s_jmp_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.PC_SIZE(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .flush(flush), .hold(hold), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .opnd_rdy(opnd_rdy), .b_eval(b_eval), .branch_outcome(branch_outcome),
        .trgt_gen(trgt_gen), .alupc(alupc), .jr_bpu(jr_bpu), .jr_in(jr_in),
        .stall_req(stall_req), .br_cnt(br_cnt), .taken_cnt(taken_cnt), .jmp_cnt(jmp_cnt)
    );

    branch_resolve_unit #(.PC_SIZE(32), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .flush(flush), .hold(hold), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .opnd_rdy(opnd_rdy), .b_eval(s_b_eval), .branch_outcome(s_branch_outcome),
        .trgt_gen(s_trgt_gen), .alupc(s_alupc), .jr_bpu(s_jr_bpu), .jr_in(s_jr_in),
        .stall_req(s_stall_req), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt), .jmp_cnt(s_jmp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        instr       = 32'h0000_0013;
        pc          = 32'h0;
        flush       = 1'b0;
        hold        = 1'b0;
        rs1_val     = 32'h0;
        rs2_val     = 32'h0;
        opnd_rdy    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rs1_val = 32'h1234_5678;
        rst = 1'b1;
        #1;
        checks++;
        if ({b_eval, branch_outcome, trgt_gen, jr_bpu, stall_req} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 00000", {b_eval, branch_outcome, trgt_gen, jr_bpu, stall_req});
        end
        checks++;
        if (alupc !== 32'h0 || jr_in !== 32'h0) begin
            errors++; $display("FAIL reset_targets got alupc=%h jr_in=%h exp 0", alupc, jr_in);
        end
        checks++;
        if (br_cnt !== 32'h0 || taken_cnt !== 32'h0 || jmp_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_counters got %0d %0d %0d exp 0", br_cnt, taken_cnt, jmp_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_beq();
        do_reset();
        instr_valid = 1'b1; instr = enc_b(3'b000, 13'd16); pc = 32'h100;
        rs1_val = 32'd5; rs2_val = 32'd5; opnd_rdy = 1'b1;
        tick();
        instr_valid = 1'b0;
        #1;
        checks++;
        if (b_eval !== 1'b1 || branch_outcome !== 1'b1) begin
            errors++; $display("FAIL beq_strobe got b_eval=%b outcome=%b exp 1 1", b_eval, branch_outcome);
        end
        checks++;
        if (alupc !== 32'h110) begin
            errors++; $display("FAIL beq_alupc got %h exp 00000110", alupc);
        end
        tick();
        checks++;
        if (br_cnt !== 32'd1 || taken_cnt !== 32'd1 || b_eval !== 1'b0) begin
            errors++; $display("FAIL beq_counts got br=%0d taken=%0d b_eval=%b exp 1 1 0", br_cnt, taken_cnt, b_eval);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr_valid = 1'b1; instr = enc_b(3'b100, 13'd8); pc = 32'h300;
        rs1_val = 32'hFFFF_FFFF; rs2_val = 32'd1;
        tick();
        instr = enc_b(3'b110, 13'd8); pc = 32'h304;
        #1;
        checks++;
        if (b_eval !== 1'b1 || branch_outcome !== 1'b1) begin
            errors++; $display("FAIL blt_taken got b_eval=%b outcome=%b exp 1 1", b_eval, branch_outcome);
        end
        tick();
        instr_valid = 1'b0;
        #1;
        checks++;
        if (b_eval !== 1'b1 || branch_outcome !== 1'b0) begin
            errors++; $display("FAIL bltu_not_taken got b_eval=%b outcome=%b exp 1 0", b_eval, branch_outcome);
        end
        checks++;
        if (alupc !== 32'h30C) begin
            errors++; $display("FAIL bltu_alupc got %h exp 0000030c", alupc);
        end
        tick();
        checks++;
        if (br_cnt !== 32'd2 || taken_cnt !== 32'd1) begin
            errors++; $display("FAIL b2b_counts got br=%0d taken=%0d exp 2 1", br_cnt, taken_cnt);
        end
    endtask

    task automatic test_funct3();
        logic [2:0]  f3_t  [6] = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};
        logic [31:0] a_t   [6] = '{32'd7, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd9, 32'd9};
        logic [31:0] b_t   [6] = '{32'd8, 32'd7, 32'd0, 32'd3, 32'd9, 32'd1};
        logic        exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            instr_valid = 1'b1; instr = enc_b(f3_t[i], 13'd4); pc = 32'h500;
            rs1_val = a_t[i]; rs2_val = b_t[i];
            tick();
            instr_valid = 1'b0;
            #1;
            checks++;
            if (b_eval !== 1'b1 || branch_outcome !== exp_t[i]) begin
                errors++; $display("FAIL funct3_%0d got b_eval=%b outcome=%b exp 1 %b", i, b_eval, branch_outcome, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_jalr_stall();
        int pulses = 0;
        do_reset();
        instr_valid = 1'b1; instr = enc_jalr(12'd3); pc = 32'h600;
        rs1_val = 32'h200; opnd_rdy = 1'b0;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_req !== 1'b1 || jr_bpu !== 1'b0) begin
                errors++; $display("FAIL jalr_wait_%0d got stall=%b jr_bpu=%b exp 1 0", i, stall_req, jr_bpu);
            end
            tick();
        end
        opnd_rdy = 1'b1;
        #1;
        checks++;
        if (jr_bpu !== 1'b1 || stall_req !== 1'b0 || jr_in !== 32'h202) begin
            errors++; $display("FAIL jalr_resolve got jr_bpu=%b stall=%b jr_in=%h exp 1 0 00000202", jr_bpu, stall_req, jr_in);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (jr_bpu === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || jmp_cnt !== 32'd1) begin
            errors++; $display("FAIL jalr_single got extra=%0d jmp_cnt=%0d exp 0 1", pulses, jmp_cnt);
        end
    endtask

    task automatic test_jal_hold();
        int pulses = 0;
        do_reset();
        instr_valid = 1'b1; instr = enc_j(-21'sd64); pc = 32'h40;
        tick();
        instr_valid = 1'b0;
        hold = 1'b1;
        #1;
        checks++;
        if (trgt_gen !== 1'b1 || alupc !== 32'h0) begin
            errors++; $display("FAIL jal_target got trgt_gen=%b alupc=%h exp 1 00000000", trgt_gen, alupc);
        end
        for (int i = 0; i < 4; i++) begin
            if (trgt_gen === 1'b1) pulses++;
            tick();
        end
        hold = 1'b0;
        #1;
        if (trgt_gen === 1'b1) pulses++;
        tick();
        if (trgt_gen === 1'b1) pulses++;
        checks++;
        if (pulses !== 1 || jmp_cnt !== 32'd1) begin
            errors++; $display("FAIL jal_hold_once got pulses=%0d jmp_cnt=%0d exp 1 1", pulses, jmp_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        instr_valid = 1'b1; flush = 1'b1; instr = enc_b(3'b001, 13'd12); pc = 32'h700;
        rs1_val = 32'd1; rs2_val = 32'd2;
        tick();
        instr_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (b_eval !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL flush_no_strobe got b_eval=%b stall=%b exp 0 0", b_eval, stall_req);
        end
        tick();
        checks++;
        if (br_cnt !== 32'd0) begin
            errors++; $display("FAIL flush_br_cnt got %0d exp 0", br_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        instr_valid = 1'b1; instr = enc_jalr(12'd8); pc = 32'h800;
        rs1_val = 32'h1000; opnd_rdy = 1'b0;
        tick();
        instr_valid = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL wait_entered got stall=%b exp 1", stall_req);
        end
        rst = 1'b1;
        #1;
        opnd_rdy = 1'b1;
        #1;
        checks++;
        if ({b_eval, trgt_gen, jr_bpu, stall_req} !== 4'b0 || jr_in !== 32'h0 || alupc !== 32'h0) begin
            errors++; $display("FAIL reset_in_wait got strobes=%b jr_in=%h alupc=%h exp 0", {b_eval, trgt_gen, jr_bpu, stall_req}, jr_in, alupc);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (jr_bpu !== 1'b0 || jmp_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_drops_pending got jr_bpu=%b jmp_cnt=%0d exp 0 0", jr_bpu, jmp_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rs1_val = 32'd4; rs2_val = 32'd4; opnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_valid = 1'b1; instr = enc_b(3'b000, 13'd4); pc = 32'h900 + 32'(4 * i);
            tick();
        end
        instr_valid = 1'b0;
        tick();
        checks++;
        if (br_cnt !== 32'd20) begin
            errors++; $display("FAIL wide_br_cnt got %0d exp 20", br_cnt);
        end
        checks++;
        if (s_br_cnt !== 4'd15 || s_taken_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_cnt got br=%0d taken=%0d exp 15 15", s_br_cnt, s_taken_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_back_to_back();
        test_funct3();
        test_jalr_stall();
        test_jal_hold();
        test_flush();
        test_reset_in_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
